// File: rtl/conv1_buf_pkg.sv
// -----------------------------------------------------------------------------
// conv1_buf_pkg
// Shared CNN package: filter geometry, default feature-map size and pixel
// width, plus helpers for the line-buffer depth and window tap addressing.
// Used by the conv1 window buffer and by the convolution calculation stages.
// -----------------------------------------------------------------------------
package conv1_buf_pkg;

    // Square convolution kernel edge length.
    localparam int FILTER_SIZE = 5;

    // Default unsigned pixel width.
    localparam int DATA_BITS   = 8;

    // Default input feature-map geometry.
    localparam int IMG_WIDTH   = 28;
    localparam int IMG_HEIGHT  = 28;

    // Words needed so that the oldest tap of a FILTER_SIZE x FILTER_SIZE
    // window is still present: (FILTER_SIZE-1) full rows plus FILTER_SIZE.
    function automatic int buf_depth(input int width);
        return (FILTER_SIZE - 1) * width + FILTER_SIZE;
    endfunction

    // Buffer index feeding window tap (r, c); r=0 is the top row, c=0 the
    // left column. Index 0 is the newest pixel, i.e. the bottom-right tap.
    function automatic int tap_index(input int r, input int c, input int width);
        return (FILTER_SIZE - 1 - r) * width + (FILTER_SIZE - 1 - c);
    endfunction

endpackage

// File: rtl/conv1_buf_pos_cnt.sv
// -----------------------------------------------------------------------------
// conv1_pos_cnt
// Raster position tracker for the conv1 window buffer. Keeps the column/row
// of the next pixel to be accepted and registers the window-valid strobe when
// the accepted pixel completes a full 5x5 window inside the current frame.
//
// Ports
//   clk           in   single clock, rising edge
//   rst           in   asynchronous active-high reset
//   valid_in      in   pixel accepted on an edge where high
//   valid_out_buf out  registered window-valid strobe
// -----------------------------------------------------------------------------
module conv1_pos_cnt
    import conv1_buf_pkg::*;
#(
    parameter int WIDTH  = IMG_WIDTH,
    parameter int HEIGHT = IMG_HEIGHT
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_in,
    output logic valid_out_buf
);

    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(FILTER_SIZE - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(FILTER_SIZE - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          window_full;

    // A window is complete once at least FILTER_SIZE-1 rows and columns sit
    // above and left of the pixel. Gating on col also kills windows that
    // would straddle a row wrap, and gating on row kills windows that would
    // straddle a frame boundary, so the buffer never needs clearing.
    assign window_full = (row >= ROW_MIN) && (col >= COL_MIN);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would make row see the updated col.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col           <= '0;
            row           <= '0;
            valid_out_buf <= 1'b0;
        end else begin
            // Strobe is computed from pre-increment position and drops to 0
            // after any idle edge.
            valid_out_buf <= valid_in && window_full;
            if (valid_in) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/conv1_buf.sv
// -----------------------------------------------------------------------------
// conv1_buf
// Sliding 5x5 window generator for the first convolution layer. Pixels arrive
// in raster order; a shift buffer of 4*WIDTH+5 words holds enough history to
// expose every tap of the window whose bottom-right pixel is the newest one.
// Taps are driven straight from buffer registers.
//
// Ports
//   clk                  in   single clock, rising edge
//   rst                  in   asynchronous active-high reset
//   valid_in             in   pixel qualifier
//   data_in              in   unsigned pixel, DATA_BITS wide
//   data_out_0..24       out  window taps, data_out_(5r+c) = row r, column c
//   valid_out_buf        out  window-valid strobe for the convolution stage
// -----------------------------------------------------------------------------
module conv1_buf
    import conv1_buf_pkg::*;
#(
    parameter int WIDTH     = IMG_WIDTH,
    parameter int HEIGHT    = IMG_HEIGHT,
    parameter int DATA_BITS = conv1_buf_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [DATA_BITS-1:0] data_in,
    output logic [DATA_BITS-1:0] data_out_0,
    output logic [DATA_BITS-1:0] data_out_1,
    output logic [DATA_BITS-1:0] data_out_2,
    output logic [DATA_BITS-1:0] data_out_3,
    output logic [DATA_BITS-1:0] data_out_4,
    output logic [DATA_BITS-1:0] data_out_5,
    output logic [DATA_BITS-1:0] data_out_6,
    output logic [DATA_BITS-1:0] data_out_7,
    output logic [DATA_BITS-1:0] data_out_8,
    output logic [DATA_BITS-1:0] data_out_9,
    output logic [DATA_BITS-1:0] data_out_10,
    output logic [DATA_BITS-1:0] data_out_11,
    output logic [DATA_BITS-1:0] data_out_12,
    output logic [DATA_BITS-1:0] data_out_13,
    output logic [DATA_BITS-1:0] data_out_14,
    output logic [DATA_BITS-1:0] data_out_15,
    output logic [DATA_BITS-1:0] data_out_16,
    output logic [DATA_BITS-1:0] data_out_17,
    output logic [DATA_BITS-1:0] data_out_18,
    output logic [DATA_BITS-1:0] data_out_19,
    output logic [DATA_BITS-1:0] data_out_20,
    output logic [DATA_BITS-1:0] data_out_21,
    output logic [DATA_BITS-1:0] data_out_22,
    output logic [DATA_BITS-1:0] data_out_23,
    output logic [DATA_BITS-1:0] data_out_24,
    output logic                 valid_out_buf
);

    localparam int BUF_DEPTH = buf_depth(WIDTH);
    localparam int NUM_TAPS  = FILTER_SIZE * FILTER_SIZE;

    logic [DATA_BITS-1:0] buffer [BUF_DEPTH];
    logic [DATA_BITS-1:0] taps   [NUM_TAPS];

    // ------------------------------------------------------------------
    // Shift buffer: index 0 is the newest pixel.
    // ------------------------------------------------------------------
    // NOTE: the buffer is reset word by word so every tap reads 0 right after
    // reset; this costs a reset net on each flop but keeps outputs defined.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buffer[i] <= '0;
            end
        end else if (valid_in) begin
            buffer[0] <= data_in;
            for (int i = 1; i < BUF_DEPTH; i++) begin
                buffer[i] <= buffer[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Window taps, straight from the buffer registers.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        assign taps[k] = buffer[tap_index(k / FILTER_SIZE, k % FILTER_SIZE, WIDTH)];
    end

    assign data_out_0  = taps[0];
    assign data_out_1  = taps[1];
    assign data_out_2  = taps[2];
    assign data_out_3  = taps[3];
    assign data_out_4  = taps[4];
    assign data_out_5  = taps[5];
    assign data_out_6  = taps[6];
    assign data_out_7  = taps[7];
    assign data_out_8  = taps[8];
    assign data_out_9  = taps[9];
    assign data_out_10 = taps[10];
    assign data_out_11 = taps[11];
    assign data_out_12 = taps[12];
    assign data_out_13 = taps[13];
    assign data_out_14 = taps[14];
    assign data_out_15 = taps[15];
    assign data_out_16 = taps[16];
    assign data_out_17 = taps[17];
    assign data_out_18 = taps[18];
    assign data_out_19 = taps[19];
    assign data_out_20 = taps[20];
    assign data_out_21 = taps[21];
    assign data_out_22 = taps[22];
    assign data_out_23 = taps[23];
    assign data_out_24 = taps[24];

    // ------------------------------------------------------------------
    // Raster position and window-valid qualification.
    // ------------------------------------------------------------------
    conv1_pos_cnt #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_pos_cnt (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .valid_out_buf (valid_out_buf)
    );

endmodule

// File: tb/tb_conv1_buf.sv
// -----------------------------------------------------------------------------
// tb_conv1_buf
// Self-checking bench for conv1_buf. A reference model keeps the list of
// pixels accepted since reset; tap (r,c) is the pixel accepted
// (4-r)*W+(4-c) acceptances ago, and the strobe is raised when the frame
// position of the last accepted pixel has row>=4 and col>=4.
// -----------------------------------------------------------------------------
module tb_conv1_buf;
    import conv1_buf_pkg::*;

    localparam int W     = 28;
    localparam int H     = 28;
    localparam int DB    = 8;
    localparam int DEPTH = 4 * W + 5;
    localparam int FRAME = W * H;

    logic          clk;
    logic          rst;
    logic          valid_in;
    logic [DB-1:0] data_in;
    logic [DB-1:0] taps [25];
    logic          valid_out_buf;

    int vectors     = 0;
    int miscompares = 0;

    conv1_buf #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
        .data_out_0(taps[0]),   .data_out_1(taps[1]),   .data_out_2(taps[2]),
        .data_out_3(taps[3]),   .data_out_4(taps[4]),   .data_out_5(taps[5]),
        .data_out_6(taps[6]),   .data_out_7(taps[7]),   .data_out_8(taps[8]),
        .data_out_9(taps[9]),   .data_out_10(taps[10]), .data_out_11(taps[11]),
        .data_out_12(taps[12]), .data_out_13(taps[13]), .data_out_14(taps[14]),
        .data_out_15(taps[15]), .data_out_16(taps[16]), .data_out_17(taps[17]),
        .data_out_18(taps[18]), .data_out_19(taps[19]), .data_out_20(taps[20]),
        .data_out_21(taps[21]), .data_out_22(taps[22]), .data_out_23(taps[23]),
        .data_out_24(taps[24]),
        .valid_out_buf(valid_out_buf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // ---------------- reference model ----------------
    int  hist[$];          // accepted pixels since reset, oldest first
    int  accepted = 0;     // pixels accepted since reset
    bit  exp_valid = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
            accepted  = 0;
            exp_valid = 1'b0;
        end else if (valid_in) begin
            int pos;
            pos       = accepted % FRAME;
            exp_valid = (pos / W >= 4) && (pos % W >= 4);
            accepted++;
            hist.push_back(int'(data_in));
            if (hist.size() > DEPTH) void'(hist.pop_front());
        end else begin
            exp_valid = 1'b0;
        end
    end

    function automatic int exp_tap(input int k);
        int age;
        age = (4 - k / 5) * W + (4 - k % 5);
        if (age < hist.size()) return hist[hist.size() - 1 - age];
        return 0;
    endfunction

    // ---------------- per-cycle compare ----------------
    bit checking = 1'b0;

    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < 25; k++) begin
                check($sformatf("tap%0d", k), int'(taps[k]), exp_tap(k));
            end
            check("valid_out_buf", int'(valid_out_buf), int'(exp_valid));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic vld, input logic [DB-1:0] v);
        valid_in = vld;
        data_in  = v;
        @(posedge clk);
        #2;
    endtask

    // Streams one frame of ramp pixels (index mod 256). Returns strobes seen
    // over the frame and over its first 116 pixels. lit enables the
    // hand-computed ramp expectations.
    task automatic ramp(input bit bubbles, input bit lit, input int n_pix,
                        output int strobes, output int early);
        int i;
        strobes = 0;
        early   = 0;
        i       = 0;
        while (i < n_pix) begin
            if (bubbles && $urandom_range(0, 99) < 30) begin
                step(1'b0, DB'($urandom));
                check("idle_no_strobe", int'(valid_out_buf), 0);
            end else begin
                step(1'b1, DB'(i));
                if (valid_out_buf === 1'b1) begin
                    strobes++;
                    if (i < 116) early++;
                end
                if (lit) begin
                    case (i)
                        115: check("no_strobe_115", int'(valid_out_buf), 0);
                        116: begin
                            check("strobe_116", int'(valid_out_buf), 1);
                            check("first_tap0",  int'(taps[0]),  0);
                            check("first_tap4",  int'(taps[4]),  4);
                            check("first_tap20", int'(taps[20]), 112);
                            check("first_tap24", int'(taps[24]), 116);
                        end
                        139: check("strobe_139", int'(valid_out_buf), 1);
                        140, 141, 142, 143:
                             check("wrap_suppress", int'(valid_out_buf), 0);
                        144: begin
                            check("strobe_144", int'(valid_out_buf), 1);
                            check("wrap_tap0",  int'(taps[0]), 28);
                        end
                        default: ;
                    endcase
                end
                i++;
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int s, e;
        rst      = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        step(1'b1, 8'hAA);
        step(1'b1, 8'h55);
        check("reset_tap0",  int'(taps[0]),  0);
        check("reset_tap24", int'(taps[24]), 0);
        check("reset_valid", int'(valid_out_buf), 0);
        rst      = 1'b0;
        checking = 1'b1;

        // Ramp frame with hand-computed window expectations.
        ramp(1'b0, 1'b1, FRAME, s, e);
        check("ramp_strobes", s, 576);

        // Two back-to-back frames, continuing straight from the previous one.
        ramp(1'b0, 1'b0, FRAME, s, e);
        check("b2b_f1_strobes", s, 576);
        ramp(1'b0, 1'b0, FRAME, s, e);
        check("b2b_f2_strobes", s, 576);
        check("b2b_f2_early", e, 0);

        // Ramp frame with ~30% bubbles.
        ramp(1'b1, 1'b1, FRAME, s, e);
        check("bubble_strobes", s, 576);

        // Mid-frame reset after pixel 300, then a fresh frame.
        ramp(1'b0, 1'b0, 301, s, e);
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 25; k++) check($sformatf("async_rst_tap%0d", k), int'(taps[k]), 0);
        check("async_rst_valid", int'(valid_out_buf), 0);
        step(1'b1, 8'h77);   // must not be accepted while rst is high
        rst = 1'b0;
        check("rst_hold_tap24", int'(taps[24]), 0);
        ramp(1'b0, 1'b1, FRAME, s, e);
        check("post_rst_strobes", s, 576);
        check("post_rst_early", e, 0);

        step(1'b0, '0);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv1_buf.md
CONV1_BUF -- requirements
Module: conv1_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 28, meaning input feature-map columns.
REQ-002 SHALL have parameter HEIGHT, default 28, meaning input feature-map rows.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning unsigned pixel width.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port valid_in  input  1  pixel qualifier; data_in accepted on an edge where it is high.
REQ-007 SHALL have port data_in  input  DATA_BITS  unsigned pixel, raster order (row-major, top-left first).
REQ-008 SHALL have ports data_out_0 .. data_out_24  output  DATA_BITS each  5x5 window taps; data_out_(5r+c) = window row r (0 = top), column c (0 = left).
REQ-009 SHALL have port valid_out_buf  output  1  window-valid strobe for the downstream convolution stage.

Function
REQ-010 SHALL hold a shift buffer of BUF_DEPTH = 4*WIDTH+5 words (117 at defaults); index 0 holds the newest pixel.
REQ-011 SHALL, on each edge with valid_in=1, shift the buffer by one word and write data_in into index 0; with valid_in=0, SHALL hold the buffer unchanged.
REQ-012 SHALL drive data_out_(5r+c) from buffer index (4-r)*WIDTH+(4-c), directly from registers with no additional stage.
REQ-013 SHALL keep column counter col (0..WIDTH-1) and row counter row (0..HEIGHT-1), both giving the position of the next pixel to be accepted.
REQ-014 SHALL increment col per accepted pixel; at col=WIDTH-1, col wraps to 0 and row increments; at (HEIGHT-1, WIDTH-1), both wrap to 0 (frame end).
REQ-015 SHALL register valid_out_buf=1 on an edge that accepts a pixel with row>=4 and col>=4 (pre-increment values); otherwise it SHALL register 0.
REQ-016 Latency: the window containing an accepted pixel (at data_out_24) SHALL appear, together with valid_out_buf=1, in the cycle after the accepting edge.
REQ-017 SHALL produce exactly (WIDTH-4)*(HEIGHT-4) strobes per frame (576 at defaults), each one cycle wide.
REQ-018 Bubbles on valid_in SHALL NOT alter window contents or strobe count; valid_out_buf SHALL be 0 in every cycle following a non-accepting edge.
REQ-019 Pixels at col<4 SHALL never raise the strobe, so windows straddling a row wrap are suppressed.
REQ-020 Buffer contents SHALL NOT be cleared at frame end; the counter gating alone suppresses windows spanning two frames.
REQ-021 Back-to-back frames with no gap SHALL be supported; the pixel after frame end is treated as (0,0).

Reset
REQ-022 On rst=1, SHALL asynchronously clear all buffer words, col, row and valid_out_buf to 0, so every output reads 0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame; the first pixel accepted after release SHALL be position (0,0).
REQ-024 SHALL accept no pixel on an edge where rst=1.

Structure
REQ-025 SHALL take FILTER_SIZE=5, DATA_BITS, WIDTH, HEIGHT and the BUF_DEPTH expression from the shared CNN package, which is also used by the convolution calculation stages.
REQ-026 SHALL place the col/row counters and window-valid qualification in one sub-module, conv1_pos_cnt, with the shift buffer in the top module.

Verification
REQ-027 Reset: assert rst mid-stream -> all 25 taps = 0 and valid_out_buf = 0 immediately, without waiting for a clock edge.
REQ-028 Ramp frame: stream pixel value (index mod 256) continuously -> first strobe in the cycle after index 116; data_out_0=0, data_out_4=4, data_out_20=112, data_out_24=116; 576 strobes in total.
REQ-029 Row wrap: same ramp -> strobe after index 139 (row 4, col 27); no strobe for indices 140-143; next strobe after index 144 with data_out_0=28.
REQ-030 Bubbles: same ramp with valid_in randomly low 30% of cycles -> exactly the same 576 windows, in order, with no strobe after any idle edge.
REQ-031 Back-to-back frames: two ramps without a gap -> no strobe for the first 116 pixels of frame 2; 1152 strobes in total.
REQ-032 Mid-frame reset: pulse rst after pixel 300, then send a full frame -> first strobe after the 117th new pixel; 576 strobes.
